// File: rtl/uart_pkg.sv
// Shared types for the UART receive-side buffer: byte width and capture FSM states.
package uart_pkg;

   localparam int BYTE_W = 8;

   // IDLE waits for a new byte from uartRx; WAIT holds off until READY drops
   // so a slow READY_CLR response never causes a second capture.
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } cap_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle of the uartRx-facing and host-facing signals of the receive FIFO.
// master = the environment (uartRx + host), slave = the FIFO itself.
interface uart_rx_fifo_if #(
   parameter int ADDR_W = 4
);
   import uart_pkg::*;

   logic              rx_ready;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_clr;
   logic              rd_en;
   logic [BYTE_W-1:0] dout;
   logic              dout_valid;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              overrun;
   logic              ovr_clr;

   modport master (
      output rx_ready, rx_data, rd_en, ovr_clr,
      input  rx_clr, dout, dout_valid, empty, full, count, overrun
   );

   modport slave (
      input  rx_ready, rx_data, rd_en, ovr_clr,
      output rx_clr, dout, dout_valid, empty, full, count, overrun
   );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x 8 storage array with one write port and one registered read port.
// The read register doubles as the FIFO's DOUT, so it holds between reads.
module sync_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BYTE_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [BYTE_W-1:0] rd_data
);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [BYTE_W-1:0] rd_data_reg;

   // Write port: contents are not reset, stale bytes are unreachable via the pointers.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port; cleared on reset so DOUT starts at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_reg <= '0;
      end else if (rd_en) begin
         rd_data_reg <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind uartRx: captures each byte once into a FIFO,
// acknowledges it with a one-cycle RX_CLR pulse, and serves the host through
// a read-enable port with count/full/empty and a sticky overrun flag.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_fifo_if.slave  bus
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   cap_state_t        state_reg;
   cap_state_t        state_next;
   logic              capture;
   logic              wr_en;
   logic              drop;
   logic              pop;
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [ADDR_W:0]   count_reg;
   logic [ADDR_W:0]   count_next;
   logic              empty_reg;
   logic              full_reg;
   logic              overrun_reg;
   logic              rx_clr_reg;
   logic              dout_valid_reg;

   // Capture FSM: take a byte on READY in IDLE, then wait for READY to fall.
   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.rx_ready) begin
               capture    = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (!bus.rx_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Full/empty decisions use the registered count from the start of the cycle.
   assign wr_en = capture && !full_reg;
   assign drop  = capture && full_reg;
   assign pop   = bus.rd_en && !empty_reg;

   // Occupancy after this edge's write and/or pop.
   always_comb begin
      count_next = count_reg;
      if (wr_en && !pop) begin
         count_next = count_reg + CNT_ONE;
      end else if (!wr_en && pop) begin
         count_next = count_reg - CNT_ONE;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Pointers, occupancy, flags and handshake pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         empty_reg      <= 1'b1;
         full_reg       <= 1'b0;
         overrun_reg    <= 1'b0;
         rx_clr_reg     <= 1'b0;
         dout_valid_reg <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         count_reg      <= count_next;
         empty_reg      <= (count_next == '0);
         full_reg       <= (count_next == DEPTH_CNT);
         rx_clr_reg     <= capture;
         dout_valid_reg <= pop;
         // A drop in the same cycle as a clear request keeps the flag set.
         if (drop) begin
            overrun_reg <= 1'b1;
         end else if (bus.ovr_clr) begin
            overrun_reg <= 1'b0;
         end
      end
   end

   sync_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_reg),
      .wr_data (bus.rx_data),
      .rd_en   (pop),
      .rd_addr (rd_ptr_reg),
      .rd_data (bus.dout)
   );

   assign bus.rx_clr     = rx_clr_reg;
   assign bus.dout_valid = dout_valid_reg;
   assign bus.empty      = empty_reg;
   assign bus.full       = full_reg;
   assign bus.count      = count_reg;
   assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a table of directed vectors, hand-written
// corner-case sequences and a randomized phase, all checked against a queue-based
// reference model of the receive buffer.
module tb_uart_rx_fifo;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus_if ();

   uart_rx_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the FIFO contents as a queue plus the visible flags.
   logic [7:0] mq[$];
   logic       m_ovr;
   logic       m_clr;
   logic       m_dv;
   logic [7:0] m_dout;
   logic       m_taken;   // current READY assertion already acknowledged

   typedef struct packed {
      logic       rst;
      logic       rx_ready;
      logic [7:0] rx_data;
      logic       rd_en;
      logic       ovr_clr;
      int         e_count;
      logic       e_empty;
      logic       e_full;
      logic       e_ovr;
      logic       e_clr;
      logic       e_dv;
      logic [7:0] e_dout;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge of the intended behaviour, from the inputs present at the edge.
   task automatic model_edge();
      bit cap;
      bit pop;
      bit was_full;
      if (rst) begin
         mq.delete();
         m_ovr   = 1'b0;
         m_clr   = 1'b0;
         m_dv    = 1'b0;
         m_dout  = 8'h00;
         m_taken = 1'b0;
      end else begin
         cap      = bus_if.rx_ready && !m_taken;
         pop      = bus_if.rd_en && (mq.size() > 0);
         was_full = (mq.size() == DEPTH);
         if (pop) m_dout = mq.pop_front();
         m_dv = pop;
         if (cap && !was_full) mq.push_back(bus_if.rx_data);
         if (cap && was_full) m_ovr = 1'b1;
         else if (bus_if.ovr_clr) m_ovr = 1'b0;
         m_clr   = cap;
         m_taken = bus_if.rx_ready && (m_taken || cap);
      end
   endtask

   task automatic check_model();
      chk("mdl_count",   int'(bus_if.count),      mq.size());
      chk("mdl_empty",   int'(bus_if.empty),      int'(mq.size() == 0));
      chk("mdl_full",    int'(bus_if.full),       int'(mq.size() == DEPTH));
      chk("mdl_overrun", int'(bus_if.overrun),    int'(m_ovr));
      chk("mdl_rx_clr",  int'(bus_if.rx_clr),     int'(m_clr));
      chk("mdl_dvalid",  int'(bus_if.dout_valid), int'(m_dv));
      chk("mdl_dout",    int'(bus_if.dout),       int'(m_dout));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic set_in(input logic r, input logic rr, input logic [7:0] d,
                         input logic re, input logic oc);
      rst             = r;
      bus_if.rx_ready = rr;
      bus_if.rx_data  = d;
      bus_if.rd_en    = re;
      bus_if.ovr_clr  = oc;
   endtask

   // Present one byte, wait (bounded) for the acknowledge, hold READY for a
   // further 'hold' cycles to mimic a slow clear, then release READY.
   task automatic send_byte(input logic [7:0] d, input int hold);
      bus_if.rx_ready = 1'b1;
      bus_if.rx_data  = d;
      step();
      for (int k = 0; k < 8 && !bus_if.rx_clr; k++) step();
      chk("rx_clr_seen", int'(bus_if.rx_clr), 1);
      for (int k = 0; k < hold; k++) step();
      bus_if.rx_ready = 1'b0;
      step();
   endtask

   task automatic pop_check(input logic [7:0] exp);
      bus_if.rd_en = 1'b1;
      step();
      bus_if.rd_en = 1'b0;
      chk("pop_valid", int'(bus_if.dout_valid), 1);
      chk("pop_data",  int'(bus_if.dout), int'(exp));
      $display("pop: dout=%02h expected=%02h count=%0d", bus_if.dout, exp, bus_if.count);
   endtask

   task automatic do_reset();
      set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      // rst rx_ready data rd_en ovr_clr | count empty full ovr clr dv dout
      tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[2] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
      tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
      tbl[7] = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[8] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};

      // Directed table: single byte in/out, reset overriding a pending byte.
      for (int i = 0; i < 10; i++) begin
         set_in(tbl[i].rst, tbl[i].rx_ready, tbl[i].rx_data, tbl[i].rd_en, tbl[i].ovr_clr);
         step();
         chk("tbl_count", int'(bus_if.count),      tbl[i].e_count);
         chk("tbl_empty", int'(bus_if.empty),      int'(tbl[i].e_empty));
         chk("tbl_full",  int'(bus_if.full),       int'(tbl[i].e_full));
         chk("tbl_ovr",   int'(bus_if.overrun),    int'(tbl[i].e_ovr));
         chk("tbl_clr",   int'(bus_if.rx_clr),     int'(tbl[i].e_clr));
         chk("tbl_dv",    int'(bus_if.dout_valid), int'(tbl[i].e_dv));
         chk("tbl_dout",  int'(bus_if.dout),       int'(tbl[i].e_dout));
         $display("vec %0d: count=%0d clr=%0b dv=%0b dout=%02h", i, bus_if.count,
                  bus_if.rx_clr, bus_if.dout_valid, bus_if.dout);
      end
      set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step();

      // Slow clear: READY held 5 cycles after the acknowledge -> one write.
      send_byte(8'h11, 5);
      chk("slow_clr_count", int'(bus_if.count), 1);
      pop_check(8'h11);

      // Fill to full, drop the 17th, drain in order.
      for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 0);
      chk("fill_full",  int'(bus_if.full), 1);
      chk("fill_count", int'(bus_if.count), DEPTH);
      send_byte(8'hFF, 0);
      chk("drop_ovr",   int'(bus_if.overrun), 1);
      chk("drop_count", int'(bus_if.count), DEPTH);
      for (int i = 0; i < DEPTH; i++) pop_check(8'(i));
      chk("drain_empty", int'(bus_if.empty), 1);
      bus_if.ovr_clr = 1'b1;
      step();
      bus_if.ovr_clr = 1'b0;
      chk("ovr_cleared", int'(bus_if.overrun), 0);

      // Simultaneous write and pop at COUNT=3.
      for (int i = 0; i < 3; i++) send_byte(8'h20 + 8'(i), 0);
      bus_if.rx_ready = 1'b1;
      bus_if.rx_data  = 8'h23;
      bus_if.rd_en    = 1'b1;
      step();
      bus_if.rd_en = 1'b0;
      chk("sim3_count", int'(bus_if.count), 3);
      chk("sim3_dout",  int'(bus_if.dout), 8'h20);
      bus_if.rx_ready = 1'b0;
      step();
      for (int i = 1; i < 4; i++) pop_check(8'h20 + 8'(i));

      // Simultaneous write and pop at COUNT=16: pop wins, write dropped.
      for (int i = 0; i < DEPTH; i++) send_byte(8'h30 + 8'(i), 0);
      bus_if.rx_ready = 1'b1;
      bus_if.rx_data  = 8'hEE;
      bus_if.rd_en    = 1'b1;
      step();
      bus_if.rd_en = 1'b0;
      chk("sim16_count", int'(bus_if.count), DEPTH - 1);
      chk("sim16_ovr",   int'(bus_if.overrun), 1);
      bus_if.rx_ready = 1'b0;
      step();
      for (int i = 1; i < DEPTH; i++) pop_check(8'h30 + 8'(i));

      // Wrap: 40 bytes with occupancy never above 4.
      for (int i = 0; i < 40; i++) begin
         send_byte(8'h80 + 8'(i), i % 3);
         if (i % 4 == 3) begin
            for (int j = 3; j >= 0; j--) pop_check(8'h80 + 8'(i - j));
         end
      end

      // Reset with COUNT=7, FSM waiting on READY, overrun still set from above.
      for (int i = 0; i < 6; i++) send_byte(8'h50 + 8'(i), 0);
      bus_if.rx_ready = 1'b1;
      bus_if.rx_data  = 8'h56;
      step();
      for (int k = 0; k < 8 && !bus_if.rx_clr; k++) step();
      chk("pre_rst_count", int'(bus_if.count), 7);
      set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      chk("rst_count", int'(bus_if.count), 0);
      chk("rst_empty", int'(bus_if.empty), 1);
      chk("rst_ovr",   int'(bus_if.overrun), 0);
      chk("rst_dout",  int'(bus_if.dout), 0);
      bus_if.rd_en = 1'b1;
      step();
      bus_if.rd_en = 1'b0;
      chk("rst_no_dv", int'(bus_if.dout_valid), 0);

      // Overrun set and clear in the same cycle: set wins.
      for (int i = 0; i < DEPTH; i++) send_byte(8'hC0 + 8'(i), 0);
      bus_if.rx_ready = 1'b1;
      bus_if.rx_data  = 8'hDD;
      bus_if.ovr_clr  = 1'b1;
      step();
      bus_if.ovr_clr = 1'b0;
      chk("setclr_ovr", int'(bus_if.overrun), 1);
      bus_if.rx_ready = 1'b0;
      step();
      do_reset();

      // Randomized traffic: random bytes, clear latency, reads, clears, resets.
      begin
         bit acked = 1'b0;
         for (int c = 0; c < 4000; c++) begin
            int rd_pct;
            rd_pct = (c < 2000) ? 20 : 60;
            if (!bus_if.rx_ready) begin
               if ($urandom_range(99) < 35) begin
                  bus_if.rx_ready = 1'b1;
                  bus_if.rx_data  = 8'($urandom());
                  acked = 1'b0;
               end
            end else if (acked && $urandom_range(99) < 50) begin
               bus_if.rx_ready = 1'b0;
            end
            bus_if.rd_en   = ($urandom_range(99) < rd_pct);
            bus_if.ovr_clr = ($urandom_range(99) < 5);
            rst            = ($urandom_range(999) < 3);
            step();
            if (bus_if.rx_clr) acked = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
